// File: rtl/scan_timing_gen.sv
// Raster scan timing generator: pixel/line counters with registered sync, visible and strobe outputs.
// Every output describes the scan position presented in the same cycle.
module scan_timing_gen #(
  parameter int unsigned h_visible     = 640,
  parameter int unsigned h_front       = 16,
  parameter int unsigned h_sync        = 96,
  parameter int unsigned h_back        = 48,
  parameter int unsigned v_visible     = 480,
  parameter int unsigned v_front       = 10,
  parameter int unsigned v_sync        = 2,
  parameter int unsigned v_back        = 33,
  parameter int unsigned counter_width = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  output logic [counter_width-1:0] h_count,
  output logic [counter_width-1:0] v_count,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     visible,
  output logic                     line_start,
  output logic                     frame_start
);

  localparam int unsigned H_TOTAL = h_visible + h_front + h_sync + h_back;
  localparam int unsigned V_TOTAL = v_visible + v_front + v_sync + v_back;

  localparam logic [counter_width-1:0] H_LAST     = counter_width'(H_TOTAL - 1);
  localparam logic [counter_width-1:0] V_LAST     = counter_width'(V_TOTAL - 1);
  localparam logic [counter_width-1:0] H_VIS      = counter_width'(h_visible);
  localparam logic [counter_width-1:0] V_VIS      = counter_width'(v_visible);
  localparam logic [counter_width-1:0] HS_FIRST   = counter_width'(h_visible + h_front);
  localparam logic [counter_width-1:0] HS_LAST    = counter_width'(h_visible + h_front + h_sync - 1);
  localparam logic [counter_width-1:0] VS_FIRST   = counter_width'(v_visible + v_front);
  localparam logic [counter_width-1:0] VS_LAST    = counter_width'(v_visible + v_front + v_sync - 1);

  // Totals must be representable in the counters.
  if (64'(H_TOTAL) > (64'(1) << counter_width)) begin : g_h_total_check
    $error("scan_timing_gen: h_total does not fit in counter_width bits");
  end
  if (64'(V_TOTAL) > (64'(1) << counter_width)) begin : g_v_total_check
    $error("scan_timing_gen: v_total does not fit in counter_width bits");
  end

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [counter_width-1:0]   r_h_count;
  logic [counter_width-1:0]   r_v_count;
  logic                       r_hsync;
  logic                       r_vsync;
  logic                       r_visible;
  logic                       r_line_start;
  logic                       r_frame_start;

  logic [counter_width-1:0]   w_h_nxt;
  logic [counter_width-1:0]   w_v_nxt;
  logic                       w_hsync_nxt;
  logic                       w_vsync_nxt;
  logic                       w_visible_nxt;
  logic                       w_line_nxt;
  logic                       w_frame_nxt;

  // Next scan position and the outputs that describe it.
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_count;
    w_v_nxt     = r_v_count;
    w_line_nxt  = 1'b0;
    w_frame_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // First cycle out of reset presents (0,0) with both strobes.
        w_state_nxt = ST_RUN;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
        w_line_nxt  = 1'b1;
        w_frame_nxt = 1'b1;
      end
      ST_RUN: begin
        if (enable) begin
          if (r_h_count == H_LAST) begin
            w_h_nxt    = '0;
            w_line_nxt = 1'b1;
            if (r_v_count == V_LAST) begin
              w_v_nxt     = '0;
              w_frame_nxt = 1'b1;
            end else begin
              w_v_nxt = r_v_count + counter_width'(1);
            end
          end else begin
            w_h_nxt = r_h_count + counter_width'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_hsync_nxt   = !((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST));
    w_vsync_nxt   = !((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST));
    w_visible_nxt = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_h_count     <= '0;
      r_v_count     <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_visible     <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_h_count     <= w_h_nxt;
      r_v_count     <= w_v_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_visible     <= w_visible_nxt;
      r_line_start  <= w_line_nxt;
      r_frame_start <= w_frame_nxt;
    end
  end

  assign h_count     = r_h_count;
  assign v_count     = r_v_count;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign visible     = r_visible;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_scan_timing_gen.sv
// Scoreboard bench for scan_timing_gen: a linear-position reference model predicts every cycle,
// a monitor compares the DUT outputs against the queued predictions.
module tb_scan_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int CW = 6;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          hs;
    logic          vs;
    logic          vis;
    logic          ls;
    logic          fs;
  } obs_t;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          hsync;
  logic          vsync;
  logic          visible;
  logic          line_start;
  logic          frame_start;

  scan_timing_gen #(
    .h_visible(HV), .h_front(HF), .h_sync(HS), .h_back(HB),
    .v_visible(VV), .v_front(VF), .v_sync(VS), .v_back(VB),
    .counter_width(CW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .h_count(h_count), .v_count(v_count),
    .hsync(hsync), .vsync(vsync), .visible(visible),
    .line_start(line_start), .frame_start(frame_start)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: scan position as a single index into the frame.
  int p       = 0;
  bit running = 1'b0;

  task automatic step(input logic rst, input logic en);
    obs_t e;
    int   h, v;
    @(negedge clock);
    reset  = rst;
    enable = en;
    if (rst) begin
      running = 1'b0;
      e = '{h: '0, v: '0, hs: 1'b1, vs: 1'b1, vis: 1'b0, ls: 1'b0, fs: 1'b0};
    end else begin
      e.ls = 1'b0;
      e.fs = 1'b0;
      if (!running) begin
        running = 1'b1;
        p = 0;
        e.ls = 1'b1;
        e.fs = 1'b1;
      end else if (en) begin
        p = (p + 1) % FRAME;
        e.ls = ((p % HT) == 0);
        e.fs = (p == 0);
      end
      h = p % HT;
      v = p / HT;
      e.h   = CW'(h);
      e.v   = CW'(v);
      e.hs  = !(h >= HV + HF && h < HV + HF + HS);
      e.vs  = !(v >= VV + VF && v < VV + VF + VS);
      e.vis = (h < HV) && (v < VV);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one DUT observation per clock, compared with the oldest prediction.
  initial begin
    obs_t e, g;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{h: h_count, v: v_count, hs: hsync, vs: vsync, vis: visible,
              ls: line_start, fs: frame_start};
        n_checks++;
        if (g === e) n_pass++;
        else
          $display("FAIL scan_out t=%0t got h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b exp h=%0d v=%0d hs=%b vs=%b vis=%b ls=%b fs=%b",
                   $time, g.h, g.v, g.hs, g.vs, g.vis, g.ls, g.fs,
                   e.h, e.v, e.hs, e.vs, e.vis, e.ls, e.fs);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    // Reset with enable toggling, then two full frames enabled.
    step(1, 0);
    step(1, 1);
    step(1, 0);
    for (int i = 0; i < 2 * FRAME + 5; i++) step(0, 1);

    // Reset release with enable low still presents (0,0) strobes, then holds.
    step(1, 1);
    step(0, 0);
    step(0, 0);
    step(0, 1);

    // Stall at the end of line 5.
    for (int i = 0; i < FRAME && p != 5 * HT + HT - 1; i++) step(0, 1);
    for (int i = 0; i < 5; i++) step(0, 0);
    step(0, 1);
    step(0, 1);

    // Reset while both syncs are active.
    for (int i = 0; i < FRAME && p != (VV + VF + 1) * HT + (HV + HF + 2); i++) step(0, 1);
    step(1, 1);
    step(0, 1);
    step(0, 1);

    // Randomised enable with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7));
    end
    // Stall across the frame wrap.
    for (int i = 0; i < FRAME && p != FRAME - 1; i++) step(0, 1);
    step(0, 0);
    step(0, 0);
    step(0, 1);
    step(0, 1);

    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_timing_gen.md
SCAN_TIMING_GEN -- requirements
Module: scan_timing_gen

Interface
REQ-001 Parameter h_visible, default 640: visible pixels per line.
REQ-002 Parameter h_front, default 16: horizontal front-porch clocks.
REQ-003 Parameter h_sync, default 96: horizontal sync-pulse clocks.
REQ-004 Parameter h_back, default 48: horizontal back-porch clocks.
REQ-005 Parameter v_visible, default 480: visible lines per frame.
REQ-006 Parameter v_front, default 10: vertical front-porch lines.
REQ-007 Parameter v_sync, default 2: vertical sync-pulse lines.
REQ-008 Parameter v_back, default 33: vertical back-porch lines.
REQ-009 Parameter counter_width, default 10: width of h_count and v_count.
REQ-010 Port clock, input, 1: the only clock (25.2 MHz nominal); all state updates on its rising edge.
REQ-011 Port reset, input, 1: synchronous, active-high reset.
REQ-012 Port enable, input, 1: advance scan position by one pixel when high.
REQ-013 Port h_count, output, counter_width: current pixel column, 0..h_total-1.
REQ-014 Port v_count, output, counter_width: current line, 0..v_total-1.
REQ-015 Port hsync, output, 1: horizontal sync, active low.
REQ-016 Port vsync, output, 1: vertical sync, active low.
REQ-017 Port visible, output, 1: high when h_count < h_visible and v_count < v_visible.
REQ-018 Port line_start, output, 1: one-cycle strobe on entry to h_count = 0.
REQ-019 Port frame_start, output, 1: one-cycle strobe on entry to h_count = 0 and v_count = 0.

Function
REQ-020 h_total = h_visible+h_front+h_sync+h_back; v_total = v_visible+v_front+v_sync+v_back; both SHALL fit in counter_width bits, checked at elaboration.
REQ-021 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-022 All outputs SHALL be mutually coherent: hsync, vsync, visible and strobes describe the h_count/v_count presented in the same cycle.
REQ-023 With enable high, h_count SHALL increment by 1 per clock; at h_total-1 it SHALL wrap to 0 on the next clock.
REQ-024 v_count SHALL increment only on the clock where h_count wraps; at v_total-1 with h wrap, v_count SHALL wrap to 0.
REQ-025 hsync SHALL be 0 exactly for h_count in [h_visible+h_front, h_visible+h_front+h_sync-1], else 1.
REQ-026 vsync SHALL be 0 exactly for v_count in [v_visible+v_front, v_visible+v_front+v_sync-1], else 1, independent of h_count.
REQ-027 line_start SHALL be 1 only in the first cycle h_count = 0 is presented after an advance or after reset release; frame_start likewise for (0,0).
REQ-028 With enable low, h_count, v_count, hsync, vsync and visible SHALL hold; line_start and frame_start SHALL be 0.
REQ-029 enable toggling SHALL not skip or repeat any count value; each (h,v) position is presented for exactly one enabled cycle plus any stalled cycles.
REQ-030 Frame period with enable held high SHALL be exactly h_total*v_total clocks (420000 at defaults).

Reset
REQ-031 While reset is high: h_count = 0, v_count = 0, hsync = 1, vsync = 1, visible = 0, line_start = 0, frame_start = 0, regardless of enable.
REQ-032 First cycle after reset deasserts: h_count = 0, v_count = 0, visible = 1, line_start = 1, frame_start = 1; counting continues per REQ-023 if enable is high.
REQ-033 Reset asserted mid-frame SHALL take effect on the next rising edge, with no partial line or sync pulse completed.

Verification
REQ-034 Reset release, enable = 1: frame_start at cycle 0, next frame_start exactly 420000 clocks later; line_start every 800 clocks.
REQ-035 Line scan: hsync low for h_count 656..751 only (96 cycles); visible high for h_count 0..639 on line 0, low 640..799.
REQ-036 Frame scan: vsync low for v_count 490..491 only (1600 clocks); visible low on all of lines 480..524.
REQ-037 Wrap: at h=799,v=524 next cycle shows h=0,v=0, frame_start = 1, line_start = 1.
REQ-038 Stall: drop enable for 5 cycles at h=799,v=10 -> outputs hold, strobes 0; on re-enable next is h=0,v=11, line_start = 1 once.
REQ-039 Reset at h=700,v=491 (hsync/vsync low) -> next cycle all outputs at REQ-031 values; count resumes from (0,0) per REQ-032.
